ahb_bram_ctrl: RTL

- AHB-Lite slave that converts Cortex-M bus transfers into the simple dual-port block-RAM interface.
- The RAM side is: write port with address, data and 4-bit byte-lane enable; read port with address and registered 32-bit output (1-cycle latency).
- Sits directly upstream of the code/data block RAM on the processor bus.
- Zero wait states for all legal transfers; includes forwarding for read-after-write hazards.

---
 rtl/ahb_bram_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite slave in front of a simple dual-port block RAM: zero wait states, read-after-write forwarding.
// Optional misaligned-transfer ERROR response enabled by defining AHB_BRAM_ALIGN_ERR_EN.
module ahb_bram_ctrl #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] bram_addra,
  output logic [31:0]           bram_dina,
  output logic [3:0]            bram_wea,
  output logic [ADDR_WIDTH-1:0] bram_addrb,
  input  logic [31:0]           bram_doutb
);

  typedef enum logic [2:0] {IDLE, WR_DP, RD_DP, ERR1, ERR2} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            mask_q, mask_d;
  logic                  hit_q, hit_d;
  logic [31:0]           fwd_data_q, fwd_data_d;
  logic [3:0]            fwd_mask_q, fwd_mask_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;

  logic                  accept;
  logic                  misalign;
  logic [ADDR_WIDTH-1:0] haddr_word;
  logic [3:0]            mask_calc;
  logic                  unused_bits;

  assign accept      = HSEL & HTRANS[1] & HREADY;
  assign haddr_word  = HADDR[ADDR_WIDTH+1:2];
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  // Without the error path, sub-word offsets simply align down through the mask shift.
  always_comb begin
    case (HSIZE)
      3'd0:    mask_calc = 4'b0001 << HADDR[1:0];
      3'd1:    mask_calc = 4'b0011 << {HADDR[1], 1'b0};
      default: mask_calc = 4'b1111;
    endcase
  end

`ifdef AHB_BRAM_ALIGN_ERR_EN
  assign misalign = ((HSIZE == 3'd1) && HADDR[0]) ||
                    ((HSIZE >= 3'd2) && (HADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d     = IDLE;
    addr_d      = addr_q;
    mask_d      = mask_q;
    hit_d       = (state_q == RD_DP) ? 1'b0 : hit_q;
    fwd_data_d  = fwd_data_q;
    fwd_mask_d  = fwd_mask_q;
    hreadyout_d = 1'b1;
    hresp_d     = 1'b0;
    if (state_q == ERR1) begin
      state_d = ERR2;
      hresp_d = 1'b1;
    end else if (accept) begin
      if (misalign) begin
        state_d     = ERR1;
        hreadyout_d = 1'b0;
        hresp_d     = 1'b1;
      end else begin
        state_d = HWRITE ? WR_DP : RD_DP;
        addr_d  = haddr_word;
        mask_d  = mask_calc;
        // Read hits the word whose write data is on HWDATA right now: capture it.
        if (!HWRITE && (state_q == WR_DP) && (haddr_word == addr_q)) begin
          hit_d      = 1'b1;
          fwd_data_d = HWDATA;
          fwd_mask_d = mask_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      mask_q      <= '0;
      hit_q       <= 1'b0;
      fwd_data_q  <= '0;
      fwd_mask_q  <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mask_q      <= mask_d;
      hit_q       <= hit_d;
      fwd_data_q  <= fwd_data_d;
      fwd_mask_q  <= fwd_mask_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

`ifdef AHB_BRAM_ALIGN_ERR_EN
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;
`else
  logic unused_resp;
  assign unused_resp = hreadyout_q ^ hresp_q;
  assign HREADYOUT   = 1'b1;
  assign HRESP       = 1'b0;
`endif

  assign bram_wea   = ((state_q == WR_DP) && !rst) ? mask_q : 4'b0000;
  assign bram_addra = addr_q;
  assign bram_dina  = HWDATA;
  assign bram_addrb = haddr_word;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    always_comb begin
      HRDATA[8*gi +: 8] = 8'h00;
      if ((state_q == RD_DP) && !rst)
        HRDATA[8*gi +: 8] = (hit_q && fwd_mask_q[gi]) ? fwd_data_q[8*gi +: 8]
                                                       : bram_doutb[8*gi +: 8];
    end
  end

endmodule
